mux_nto1_reg: RTL and testbench



---
 rtl/mux_pkg.sv | 35 +++
 rtl/dual_rail_sel_chk.sv | 24 ++
 rtl/mux_nto1_reg.sv | 137 +++++++++++++
 tb/tb_mux_nto1_reg.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and dual-rail select helpers for the mux family
package mux_pkg;

   localparam logic MODE_EXT  = 1'b0;
   localparam logic MODE_SCAN = 1'b1;

   // Widest select any mux in this family carries (NUM_IN up to 16).
   localparam int SEL_MAX_W = 4;

   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   // A select is legal when every used bit of the two rails disagrees and the
   // index names an existing input. Callers zero-extend both rails.
   function automatic logic sel_legal(
      input logic [SEL_MAX_W-1:0] sel_true,
      input logic [SEL_MAX_W-1:0] sel_comp,
      input int                   sel_w,
      input int                   num_in
   );
      logic ok;
      ok = (int'(sel_true) < num_in);
      for (int i = 0; i < SEL_MAX_W; i++) begin
         if ((i < sel_w) && (sel_true[i] == sel_comp[i])) begin
            ok = 1'b0;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/dual_rail_sel_chk.sv
// rtl/dual_rail_sel_chk.sv - combinational dual-rail select check and index decode
module dual_rail_sel_chk
   import mux_pkg::*;
#(
   parameter int NUM_IN = 3,
   parameter int SEL_W  = clog2(NUM_IN)
) (
   input  logic [SEL_W-1:0] sel_true,
   input  logic [SEL_W-1:0] sel_comp,
   output logic             legal,
   output logic [SEL_W-1:0] idx
);

   logic [SEL_MAX_W-1:0] true_ext;
   logic [SEL_MAX_W-1:0] comp_ext;

   always_comb begin
      true_ext = SEL_MAX_W'(sel_true);
      comp_ext = SEL_MAX_W'(sel_comp);
      legal    = sel_legal(true_ext, comp_ext, SEL_W, NUM_IN);
      idx      = sel_true;
   end

endmodule

// File: rtl/mux_nto1_reg.sv
// rtl/mux_nto1_reg.sv - registered N-to-1 mux with dual-rail select check, error count and scan mode
module mux_nto1_reg
   import mux_pkg::*;
#(
   parameter int  WIDTH  = 1,
   parameter int  NUM_IN = 3,
   parameter int  ERR_W  = 8,
   localparam int SEL_W  = clog2(NUM_IN)
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic [NUM_IN*WIDTH-1:0] In,
   input  logic [SEL_W-1:0]        Select,
   input  logic [SEL_W-1:0]        _Select,
   input  logic                    InValid,
   input  logic                    Mode,
   input  logic                    ClearErr,
   output logic [WIDTH-1:0]        Out,
   output logic                    OutValid,
   output logic                    SelErr,
   output logic [ERR_W-1:0]        ErrCount,
   output logic [SEL_W-1:0]        ScanIdx
);

   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
   localparam logic [SEL_W-1:0] SCAN_TOP = SEL_W'(NUM_IN - 1);

   logic [WIDTH-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic             sel_err_q, sel_err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [SEL_W-1:0] scan_idx_q, scan_idx_d;
   logic             mode_q, mode_d;

   logic             chk_legal;
   logic [SEL_W-1:0] chk_idx;
   logic             scan_mode;
   logic             mode_rise;
   logic [SEL_W-1:0] scan_base;
   logic [SEL_W-1:0] pick_idx;
   logic [WIDTH-1:0] pick_data;
   logic             take;
   logic             bad_sel;

   dual_rail_sel_chk #(
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) u_sel_chk (
      .sel_true (Select),
      .sel_comp (_Select),
      .legal    (chk_legal),
      .idx      (chk_idx)
   );

   // Entering scan mode restarts the pointer so the first scan sample is input 0.
   always_comb begin
      scan_mode = (Mode == MODE_SCAN);
      mode_rise = scan_mode && (mode_q == MODE_EXT);
      scan_base = mode_rise ? '0 : scan_idx_q;
      pick_idx  = scan_mode ? scan_base : chk_idx;
      take      = InValid && (scan_mode || chk_legal);
      bad_sel   = InValid && !scan_mode && !chk_legal;
   end

   always_comb begin
      pick_data = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (pick_idx == SEL_W'(k)) begin
            pick_data = In[k*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      out_d       = out_q;
      out_valid_d = take;
      scan_idx_d  = scan_idx_q;
      mode_d      = Mode;

      if (take) begin
         out_d = pick_data;
      end

      if (scan_mode) begin
         if (InValid) begin
            scan_idx_d = (scan_base == SCAN_TOP) ? '0 : scan_base + 1'b1;
         end else begin
            scan_idx_d = scan_base;
         end
      end
   end

   // A new error outranks a same-cycle clear, leaving a count of one.
   always_comb begin
      sel_err_d = sel_err_q;
      err_cnt_d = err_cnt_q;

      if (ClearErr) begin
         sel_err_d = 1'b0;
         err_cnt_d = '0;
      end

      if (bad_sel) begin
         sel_err_d = 1'b1;
         if (ClearErr) begin
            err_cnt_d = ERR_W'(1);
         end else if (err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         sel_err_q   <= 1'b0;
         err_cnt_q   <= '0;
         scan_idx_q  <= '0;
         mode_q      <= MODE_EXT;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         sel_err_q   <= sel_err_d;
         err_cnt_q   <= err_cnt_d;
         scan_idx_q  <= scan_idx_d;
         mode_q      <= mode_d;
      end
   end

   assign Out      = out_q;
   assign OutValid = out_valid_q;
   assign SelErr   = sel_err_q;
   assign ErrCount = err_cnt_q;
   assign ScanIdx  = scan_idx_q;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// tb/tb_mux_nto1_reg.sv - randomized self-checking bench for mux_nto1_reg
module tb_mux_nto1_reg;

   localparam int WIDTH  = 8;
   localparam int NUM_IN = 3;
   localparam int ERR_W  = 2;
   localparam int SEL_W  = 2;
   localparam int CNT_MAX = (1 << ERR_W) - 1;

   logic                    clock;
   logic                    reset;
   logic [WIDTH-1:0]        din [NUM_IN];
   logic [NUM_IN*WIDTH-1:0] in_bus;
   logic [SEL_W-1:0]        sel;
   logic [SEL_W-1:0]        sel_c;
   logic                    in_valid;
   logic                    mode;
   logic                    clear_err;
   logic [WIDTH-1:0]        out;
   logic                    out_valid;
   logic                    sel_err;
   logic [ERR_W-1:0]        err_count;
   logic [SEL_W-1:0]        scan_idx;

   int n_checks = 0;
   int n_errors = 0;

   int m_out, m_valid, m_err, m_cnt, m_scan, m_prev_mode;

   assign in_bus = {din[2], din[1], din[0]};

   mux_nto1_reg #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN),
      .ERR_W  (ERR_W)
   ) dut (
      .Clock    (clock),
      .Reset    (reset),
      .In       (in_bus),
      .Select   (sel),
      ._Select  (sel_c),
      .InValid  (in_valid),
      .Mode     (mode),
      .ClearErr (clear_err),
      .Out      (out),
      .OutValid (out_valid),
      .SelErr   (sel_err),
      .ErrCount (err_count),
      .ScanIdx  (scan_idx)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_out = 0; m_valid = 0; m_err = 0; m_cnt = 0; m_scan = 0; m_prev_mode = 0;
   endtask

   // Behavioural reference: one call per rising edge, using the inputs held across it.
   task automatic model_step();
      int s, sc, idx;
      bit legal, new_err;
      s       = int'(sel);
      sc      = int'(sel_c);
      legal   = (s == ((~sc) & ((1 << SEL_W) - 1))) && (s < NUM_IN);
      new_err = 0;
      m_valid = 0;
      if (mode) begin
         idx = m_prev_mode ? m_scan : 0;
         if (in_valid) begin
            m_out   = int'(din[idx]);
            m_valid = 1;
            m_scan  = (idx + 1) % NUM_IN;
         end else begin
            m_scan = idx;
         end
      end else if (in_valid) begin
         if (legal) begin
            m_out   = int'(din[s]);
            m_valid = 1;
         end else begin
            new_err = 1;
         end
      end
      if (new_err) begin
         m_err = 1;
         m_cnt = clear_err ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
      end else if (clear_err) begin
         m_err = 0;
         m_cnt = 0;
      end
      m_prev_mode = int'(mode);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".out"},       int'(out),       m_out);
      chk({tag, ".valid"},     int'(out_valid), m_valid);
      chk({tag, ".sel_err"},   int'(sel_err),   m_err);
      chk({tag, ".err_count"}, int'(err_count), m_cnt);
      chk({tag, ".scan_idx"},  int'(scan_idx),  m_scan);
   endtask

   task automatic cycle(input string tag);
      @(posedge clock);
      model_step();
      #1;
      check_all(tag);
   endtask

   task automatic drive(input logic v, input logic md, input logic [1:0] s,
                        input logic [1:0] sc, input logic clr);
      in_valid = v; mode = md; sel = s; sel_c = sc; clear_err = clr;
   endtask

   logic [WIDTH-1:0] scan_exp_out [4];
   int               scan_exp_idx [4];

   initial begin
      reset = 1'b1;
      din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'h33;
      drive(1'b0, 1'b0, 2'b00, 2'b11, 1'b0);
      model_reset();
      @(posedge clock);
      #1;
      check_all("reset");
      reset = 1'b0;

      // Legal external select
      drive(1'b1, 1'b0, 2'b01, 2'b10, 1'b0);
      cycle("legal");
      chk("plan.legal_out", int'(out), 'h22);
      chk("plan.legal_valid", int'(out_valid), 1);

      // Out-of-range index, then equal rails
      drive(1'b1, 1'b0, 2'b11, 2'b00, 1'b0);
      cycle("range");
      chk("plan.range_out", int'(out), 'h22);
      chk("plan.range_cnt", int'(err_count), 1);
      drive(1'b1, 1'b0, 2'b01, 2'b01, 1'b0);
      cycle("rails");
      chk("plan.rails_cnt", int'(err_count), 2);

      // Invalid cycle: no check, no error
      drive(1'b0, 1'b0, 2'b10, 2'b10, 1'b0);
      cycle("idle");

      drive(1'b0, 1'b0, 2'b00, 2'b11, 1'b1);
      cycle("clear");
      chk("plan.clear_cnt", int'(err_count), 0);

      // Saturation at 2^ERR_W-1, then clear racing a new error
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 2'b10, 2'b10, 1'b0);
         cycle("sat");
      end
      chk("plan.sat_cnt", int'(err_count), 3);
      drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b1);
      cycle("clr_vs_err");
      chk("plan.clr_vs_err_cnt", int'(err_count), 1);
      chk("plan.clr_vs_err_flag", int'(sel_err), 1);
      drive(1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
      cycle("clear2");

      // Scan entry with garbage on the rails
      scan_exp_out = '{8'h11, 8'h22, 8'h33, 8'h11};
      scan_exp_idx = '{1, 2, 0, 1};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 2'($urandom), 2'($urandom), 1'b0);
         cycle("scan");
         chk("plan.scan_out", int'(out), int'(scan_exp_out[i]));
         chk("plan.scan_idx", int'(scan_idx), scan_exp_idx[i]);
         chk("plan.scan_err", int'(sel_err), 0);
      end

      // Randomized traffic against the reference
      for (int i = 0; i < 500; i++) begin
         for (int k = 0; k < NUM_IN; k++) din[k] = 8'($urandom);
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         in_valid  = ($urandom_range(0, 3) != 0);
         sel       = 2'($urandom);
         sel_c     = ($urandom_range(0, 1) != 0) ? ~sel : 2'($urandom);
         clear_err = ($urandom_range(0, 15) == 0);
         cycle("rand");
      end

      // Asynchronous reset between edges in the middle of a scan
      drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
      din[0] = 8'hA5; din[1] = 8'h5A; din[2] = 8'hC3;
      cycle("prescan");
      cycle("prescan");
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("async_reset");
      #2;
      reset = 1'b0;
      cycle("post_reset");
      chk("plan.post_reset_out", int'(out), 'hA5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
